// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch/issue unit for the FSM controller. Holds a writable
//   program memory, sequences a program counter and presents one 32-bit
//   instruction word per issue slot of SLOT_CYCLES clocks.
//
//   Optional feature: define IFU_BRANCH_EN to build the branch capture logic.
//   Without it, branch/branch_offset are ignored and the PC always steps by 1.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   start               : begin execution at PC 0 (honored in IDLE/HALT)
//   load_en/addr/data   : program memory write (honored in IDLE/HALT)
//   branch, branch_offset : branch request and signed word offset
//   instruction         : issued word (registered)
//   instr_valid         : instruction holds a live program word
//   pc                  : address of the word being issued
//   busy, halted        : high in ISSUE / HALT respectively
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          ADDR_W      = 6,
    parameter int          SLOT_CYCLES = 4,
    parameter logic [9:0]  HALT_OPCODE = 10'b1111111111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              branch,
    input  logic [6:0]        branch_offset,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HALT} state_t;

    localparam int              CNT_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   slot_cnt;
    logic [31:0]        mem [0:(1 << ADDR_W) - 1];

    logic               load_ok;
    logic               slot_end;
    logic [31:0]        start_word;
    logic [ADDR_W-1:0]  next_pc;
    logic [31:0]        next_word;

    // Writes are gated by rst_n so an edge during reset cannot corrupt memory.
    assign load_ok  = rst_n && load_en && (state != S_ISSUE);
    assign slot_end = (state == S_ISSUE) && (slot_cnt == CNT_LAST);

    // A write to address 0 in the start cycle is forwarded to the first fetch.
    assign start_word = (load_ok && (load_addr == '0)) ? load_data : mem[0];
    assign next_word  = mem[next_pc];

    // NOTE: program memory has no reset; it is plain storage and clearing it
    // would need a per-word reset network that buys nothing functionally.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

`ifdef IFU_BRANCH_EN
    logic       br_flag;
    logic [6:0] br_off_q;
    logic       br_take;
    logic [6:0] br_off;

    // The branch may arrive on the last slot cycle, so the live input is
    // merged with the sticky flag; the earliest offset in the slot wins.
    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        br_take = br_flag | branch;
        br_off  = br_flag ? br_off_q : branch_offset;
        next_pc = pc + 1'b1;
        if (br_take) begin
            next_pc = pc + ADDR_W'($signed(br_off));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_flag  <= 1'b0;
            br_off_q <= '0;
        end else if (slot_end) begin
            br_flag  <= 1'b0;
        end else if ((state == S_ISSUE) && branch && !br_flag) begin
            br_flag  <= 1'b1;
            br_off_q <= branch_offset;
        end
    end
`else
    logic unused_branch;
    assign unused_branch = &{1'b0, branch, branch_offset};
    assign next_pc       = pc + 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            slot_cnt    <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        slot_cnt <= '0;
                        pc       <= '0;
                        if (start_word[31:22] == HALT_OPCODE) begin
                            state       <= S_HALT;
                            instruction <= '0;
                            instr_valid <= 1'b0;
                            busy        <= 1'b0;
                            halted      <= 1'b1;
                        end else begin
                            state       <= S_ISSUE;
                            instruction <= start_word;
                            instr_valid <= 1'b1;
                            busy        <= 1'b1;
                            halted      <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (slot_end) begin
                        slot_cnt <= '0;
                        pc       <= next_pc;
                        if (next_word[31:22] == HALT_OPCODE) begin
                            state       <= S_HALT;
                            instruction <= '0;
                            instr_valid <= 1'b0;
                            busy        <= 1'b0;
                            halted      <= 1'b1;
                        end else begin
                            instruction <= next_word;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch/issue unit feeding the FSM controller: holds a small writable program memory, sequences a program counter, and presents one 32-bit instruction word per issue slot of `SLOT_CYCLES` clocks. It is the supplier end of the controller's `instruction` interface. The controller decodes `[31:22]` opcode, `[21:17]` read reg 1, `[16:10]` immediate, `[9:5]` read reg 2 and `[4:0]` write reg. The unit consumes the controller's `branch` and `sign_extension_bits` outputs to redirect the PC.

## Interface
Parameters:
- `ADDR_W`, default 6: program memory depth is 2^ADDR_W words; also the PC width.
- `SLOT_CYCLES`, default 4: clocks per issue slot; legal values are ≥1.
- `HALT_OPCODE`, default 10'b1111111111: opcode that stops issue.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: level-sampled; begins execution at PC 0.
- `load_en`, input, 1: program write strobe; honored in IDLE and HALT only.
- `load_addr`, input, ADDR_W: program write address.
- `load_data`, input, 32: program write word.
- `branch`, input, 1: branch request from the controller.
- `branch_offset`, input, 7: signed word offset (controller `sign_extension_bits`).
- `instruction`, output, 32: issued word, registered.
- `instr_valid`, output, 1: `instruction` is a live program word.
- `pc`, output, ADDR_W: address of the word currently issued.
- `busy`, output, 1: high in ISSUE.
- `halted`, output, 1: high in HALT.

## Operation
- States are IDLE, ISSUE and HALT. Reset enters IDLE.
- Reset values: `instruction`=0, `instr_valid`=0, `pc`=0, `busy`=0, `halted`=0. The slot counter and branch flag are cleared. Memory contents are not reset.
- IDLE:
  - `load_en` writes `load_data` to `mem[load_addr]`.
  - `start` leads to ISSUE with `pc`←0, `instruction`←mem[0], `instr_valid`←1, slot counter←0.
  - If mem[0][31:22]==HALT_OPCODE, the unit goes to HALT instead.
  - When `start` and `load_en` are both high, the write happens first. The fetch sees new data if load_addr==0.
- ISSUE:
  - The slot counter counts 0..SLOT_CYCLES-1.
  - `instruction` and `pc` stay stable for the entire slot.
  - `load_en` and `start` are ignored.
- Slot end (counter==SLOT_CYCLES-1), next PC:
  - Branch taken: `pc + sext(branch_offset)`.
  - Otherwise: `pc+1`.
  - All arithmetic is modulo 2^ADDR_W, so wrap-around is legal and silent.
- Branch capture:
  - A branch is taken if `branch` was high on any cycle of the slot, including the last cycle.
  - The offset is the one presented on the first cycle `branch` was high in that slot.
  - The sticky flag clears at every slot boundary.
- Halt at slot end: if mem[next][31:22]==HALT_OPCODE, the unit goes to HALT with `pc`←next, `instruction`←0 (a NOP to the controller), `instr_valid`←0.
- HALT:
  - `halted`=1.
  - `load_en` is honored.
  - `start` restarts exactly as from IDLE.
- Asynchronous reset mid-slot aborts immediately. All outputs take their reset values and no partial write occurs.

## Timing
- Start latency: `start` sampled at edge N puts mem[0] on `instruction` after edge N, with `busy`=1.
- Slot k occupies edges N+k·SLOT_CYCLES through N+(k+1)·SLOT_CYCLES-1.
- The next word appears after edge N+(k+1)·SLOT_CYCLES.
- Branch redirect has zero bubble: the target word is issued in the slot immediately following.
- Memory read is combinational into the `instruction` register, so it has one-edge latency and no extra wait states.
- Program writes take effect on the edge where `load_en` is sampled.
- `busy`, `halted` and `instr_valid` change only on slot boundaries, on start, or on reset.

## Configuration
- `IFU_BRANCH_EN` defined:
  - The branch capture logic is present.
  - `branch` and `branch_offset` redirect the PC as described above.
- `IFU_BRANCH_EN` undefined:
  - The branch logic is compiled out.
  - `branch` and `branch_offset` are ignored and the next PC is always `pc+1`.
  - Port list is unchanged.

## Test plan
- Sequential issue, SLOT_CYCLES=4: load mem[0..2] with ADD/SUB/MUL words and mem[3] with HALT_OPCODE, then pulse `start` → words 0,1,2 each held exactly 4 clocks. After that, `halted`=1, `instruction`=0, `pc`=3.
- Branch forward: `branch`=1 with offset 7'd3 in cycle 2 of slot at pc=1 → next pc=4. Then offset 7'b1111110 (−2) at pc=4 → next pc=2.
- Branch on last slot cycle, and two assertions with different offsets in one slot → first offset used. A branch on cycle 3 of the slot is still taken.
- Wrap: ADDR_W=6 with no halt word in memory → pc runs 63→0. Offset +5 at pc=62 → pc=3.
- Reset mid-slot, with rst_n low asynchronously between edges → outputs drop to zero immediately. After release, `start` reissues mem[0].
- Load ignored during ISSUE: `load_en` to addr 2 while busy → mem[2] unchanged when issued. Load during HALT, then `start` → new contents issued.
